rv_hazard_scoreboard: RTL

RV_HAZARD_SCOREBOARD -- requirements
Module: rv_hazard_scoreboard

---
 rtl/rv_hazard_pkg.sv | 13 +
 rtl/rv_fwd_sel.sv | 25 ++
 rtl/rv_hazard_scoreboard.sv | 124 ++++++++++++
 3 files changed

// File: rtl/rv_hazard_pkg.sv
// Shared types and default sizes for the RV hazard scoreboard and its forwarding selectors.
package rv_hazard_pkg;

    localparam int NREG_DEF  = 32;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/rv_fwd_sel.sv
// Forwarding mux select for one E-stage source operand; the younger M result beats W.
module rv_fwd_sel
    import rv_hazard_pkg::*;
#(
    parameter int RAW = 5
) (
    input  logic [RAW-1:0] rs,
    input  logic [RAW-1:0] rd_m,
    input  logic           regwrite_m,
    input  logic           longlat_m,
    input  logic [RAW-1:0] rd_w,
    input  logic           regwrite_w,
    output logic [1:0]     sel
);

    // A long-latency op in M has no ALU result yet, so it cannot feed E.
    always_comb begin
        sel = FWD_RF;
        if (regwrite_m && !longlat_m && (rd_m != '0) && (rd_m == rs))
            sel = FWD_MEM;
        else if (regwrite_w && (rd_w != '0) && (rd_w == rs))
            sel = FWD_WB;
    end

endmodule

// File: rtl/rv_hazard_scoreboard.sv
// Pipeline hazard unit: long-latency scoreboard, stall/flush generation,
// E-operand forwarding selects and saturating stall/flush performance counters.
module rv_hazard_scoreboard
    import rv_hazard_pkg::*;
#(
    parameter  int NREG  = NREG_DEF,
    parameter  int NSRC  = 2,
    parameter  int CNT_W = CNT_W_DEF,
    localparam int RAW   = $clog2(NREG)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_d,
    input  logic [NSRC-1:0][RAW-1:0]  rs_d,
    input  logic [RAW-1:0]            rd_d,
    input  logic                      regwrite_d,
    input  logic                      longlat_d,
    input  logic [NSRC-1:0][RAW-1:0]  rs_e,
    input  logic                      pcsrc_e,
    input  logic [RAW-1:0]            rd_m,
    input  logic                      regwrite_m,
    input  logic                      longlat_m,
    input  logic                      mem_req_m,
    input  logic                      mem_ready_m,
    input  logic [RAW-1:0]            rd_w,
    input  logic                      regwrite_w,
    input  logic                      longlat_w,
    input  logic                      cnt_clr,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      stall_e,
    output logic                      stall_m,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic                      flush_w,
    output logic [NSRC-1:0][1:0]      fwd_sel,
    output logic [NREG-1:0]           pending,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    logic            mem_stall;
    logic            hazard_d;
    logic            clr_en;
    logic            set_en;
    logic            issue_e;
    logic [NREG-1:0] pending_nxt;

    assign mem_stall = mem_req_m & ~mem_ready_m;
    assign clr_en    = regwrite_w & longlat_w & (rd_w != '0);

    // A W writeback of the operand this cycle reaches D through the write-through file.
    always_comb begin
        hazard_d = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if ((rs_d[i] != '0) && pending[rs_d[i]] && !(clr_en && (rd_w == rs_d[i])))
                hazard_d = 1'b1;
        end
        hazard_d = hazard_d & valid_d;
    end

    // A memory wait freezes E with any taken branch inside it; the redirect lands once M releases.
    assign stall_f = hazard_d | mem_stall;
    assign stall_d = hazard_d | mem_stall;
    assign stall_e = mem_stall;
    assign stall_m = mem_stall;
    assign flush_d = pcsrc_e & ~mem_stall;
    assign flush_e = (pcsrc_e | hazard_d) & ~mem_stall;
    assign flush_w = mem_stall;

    assign issue_e = valid_d & ~stall_d & ~flush_e;
    assign set_en  = issue_e & regwrite_d & longlat_d & (rd_d != '0);

    // Set is applied after clear so a re-issued writer keeps its register busy.
    always_comb begin
        pending_nxt = pending;
        if (clr_en)
            pending_nxt[rd_w] = 1'b0;
        if (set_en)
            pending_nxt[rd_d] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_d)
                stall_cnt <= sat_inc(stall_cnt);
            if (flush_d)
                flush_cnt <= sat_inc(flush_cnt);
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_fwd
        rv_fwd_sel #(
            .RAW(RAW)
        ) u_fwd_sel (
            .rs         (rs_e[i]),
            .rd_m       (rd_m),
            .regwrite_m (regwrite_m),
            .longlat_m  (longlat_m),
            .rd_w       (rd_w),
            .regwrite_w (regwrite_w),
            .sel        (fwd_sel[i])
        );
    end

endmodule
